// File: rtl/char_console.sv
// Text-console writer: turns a char/attr stream into {attr,char} cells
// in character RAM, with cursor, control codes, clear and scroll.
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_char/in_attr
// stream in; ram_we/ram_addr/ram_data out and ram_q in (1-cycle read);
// cursor_col/cursor_row cursor position; busy = !in_ready.
module char_console #(
  parameter int COLS = 16,
  parameter int ROWS = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [7:0]              in_char,
  input  logic [7:0]              in_attr,
  output logic [3:0]              ram_we,
  output logic [6:0]              ram_addr,
  output logic [31:0]             ram_data,
  input  logic [31:0]             ram_q,
  output logic [$clog2(COLS)-1:0] cursor_col,
  output logic [$clog2(ROWS)-1:0] cursor_row,
  output logic                    busy
);

  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam logic [6:0] HALF_W = 7'(COLS / 2);
  localparam logic [6:0] SCR_LAST = 7'((ROWS - 1) * COLS / 2 - 1);
  localparam logic [6:0] LAST_W = 7'(COLS * ROWS / 2 - 1);
  localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

  typedef enum logic [2:0] {
    IDLE, PUT, CLEAR, SC_RD, SC_WAIT, SC_WR, CLR_ROW
  } state_t;

  state_t        state_q;
  logic          rdy_q;
  logic [3:0]    we_q;
  logic [6:0]    addr_q;
  logic [31:0]   data_q;
  logic [CW-1:0] col_q;
  logic [RW-1:0] row_q;

  logic [6:0] put_addr_d;
  logic       is_print, is_cr, is_lf, is_bs, is_ff;

  assign put_addr_d = 7'(row_q) * HALF_W + 7'(col_q >> 1);
  assign is_print = (in_char >= 8'h20) && (in_char != 8'h7F);
  assign is_cr = in_char == 8'h0D;
  assign is_lf = in_char == 8'h0A;
  assign is_bs = in_char == 8'h08;
  assign is_ff = in_char == 8'h0C;

  assign in_ready   = rdy_q;
  assign busy       = !rdy_q;
  assign ram_we     = we_q;
  assign ram_addr   = addr_q;
  assign ram_data   = data_q;
  assign cursor_col = col_q;
  assign cursor_row = row_q;

  // Outputs are registered alongside the state: each branch sets up
  // what the RAM port shows during the next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      rdy_q   <= 1'b0;
      we_q    <= 4'h0;
      addr_q  <= 7'd0;
      data_q  <= 32'd0;
      col_q   <= '0;
      row_q   <= '0;
    end else begin
      we_q <= 4'h0;
      unique case (state_q)
        IDLE: begin
          if (in_valid && rdy_q) begin
            unique case (1'b1)
              is_print: begin
                state_q <= PUT;
                rdy_q   <= 1'b0;
                we_q    <= col_q[0] ? 4'b1100 : 4'b0011;
                addr_q  <= put_addr_d;
                data_q  <= {in_attr, in_char, in_attr, in_char};
              end
              is_cr: col_q <= '0;
              is_lf: begin
                col_q <= '0;
                if (row_q == LAST_ROW) begin
                  state_q <= SC_RD;
                  rdy_q   <= 1'b0;
                  addr_q  <= HALF_W;
                end else begin
                  row_q <= row_q + 1'b1;
                end
              end
              is_bs: begin
                if (col_q != '0) begin
                  col_q <= col_q - 1'b1;
                end else if (row_q != '0) begin
                  row_q <= row_q - 1'b1;
                  col_q <= LAST_COL;
                end
              end
              is_ff: begin
                state_q <= CLEAR;
                rdy_q   <= 1'b0;
                col_q   <= '0;
                row_q   <= '0;
                we_q    <= 4'hF;
                addr_q  <= 7'd0;
                data_q  <= 32'd0;
              end
              default: ;
            endcase
          end
        end
        PUT: begin
          if (col_q == LAST_COL) begin
            col_q <= '0;
            if (row_q == LAST_ROW) begin
              state_q <= SC_RD;
              addr_q  <= HALF_W;
            end else begin
              row_q   <= row_q + 1'b1;
              state_q <= IDLE;
              rdy_q   <= 1'b1;
            end
          end else begin
            col_q   <= col_q + 1'b1;
            state_q <= IDLE;
            rdy_q   <= 1'b1;
          end
        end
        // After reset we_q is 0, so the first cycle only starts at word 0.
        CLEAR: begin
          data_q <= 32'd0;
          if (we_q == 4'h0) begin
            we_q   <= 4'hF;
            addr_q <= 7'd0;
          end else if (addr_q == LAST_W) begin
            state_q <= IDLE;
            rdy_q   <= 1'b1;
          end else begin
            we_q   <= 4'hF;
            addr_q <= addr_q + 7'd1;
          end
        end
        SC_RD: state_q <= SC_WAIT;
        // ram_q now holds the source word; it becomes the write data.
        SC_WAIT: begin
          state_q <= SC_WR;
          we_q    <= 4'hF;
          addr_q  <= addr_q - HALF_W;
          data_q  <= ram_q;
        end
        SC_WR: begin
          if (addr_q == SCR_LAST) begin
            state_q <= CLR_ROW;
            we_q    <= 4'hF;
            addr_q  <= addr_q + 7'd1;
            data_q  <= 32'd0;
          end else begin
            state_q <= SC_RD;
            addr_q  <= addr_q + 7'd1 + HALF_W;
          end
        end
        CLR_ROW: begin
          if (addr_q == LAST_W) begin
            state_q <= IDLE;
            rdy_q   <= 1'b1;
            col_q   <= '0;
            row_q   <= LAST_ROW;
          end else begin
            we_q   <= 4'hF;
            addr_q <= addr_q + 7'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          rdy_q   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_char_console.sv
// Bench for char_console: RAM model, write scoreboard, scenario tasks.
// Expected RAM writes are queued before stimulus and matched in order.
module tb_char_console;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_char = 8'h00;
  logic [7:0]  in_attr = 8'h00;
  logic        in_ready;
  logic [3:0]  ram_we;
  logic [6:0]  ram_addr;
  logic [31:0] ram_data;
  logic [31:0] ram_q = 32'd0;
  logic [3:0]  cursor_col;
  logic [2:0]  cursor_row;
  logic        busy;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [31:0] mem [64];
  logic [31:0] shadow [64];
  logic [42:0] exp_q [$];

  always #5 clk = ~clk;

  char_console #(.COLS(16), .ROWS(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_char(in_char), .in_attr(in_attr),
    .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_data(ram_data), .ram_q(ram_q),
    .cursor_col(cursor_col), .cursor_row(cursor_row),
    .busy(busy)
  );

  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (ram_we[b]) mem[ram_addr[5:0]][8*b +: 8] <= ram_data[8*b +: 8];
    ram_q <= mem[ram_addr[5:0]];
  end

  always @(negedge clk) begin
    logic [42:0] e;
    if (ram_we !== 4'h0) begin
      total_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_unexpected: got we=%h addr=%0d data=%h, no write required",
                 ram_we, ram_addr, ram_data);
      end else begin
        e = exp_q.pop_front();
        if ({ram_we, ram_addr, ram_data} !== e)
          $display("FAIL sb_write: got we=%h addr=%0d data=%h, required we=%h addr=%0d data=%h",
                   ram_we, ram_addr, ram_data, e[42:39], e[38:32], e[31:0]);
        else pass_cnt++;
      end
    end
  end

  function automatic void push_write(logic [3:0] we, logic [6:0] a, logic [31:0] d);
    exp_q.push_back({we, a, d});
    for (int b = 0; b < 4; b++)
      if (we[b]) shadow[a[5:0]][8*b +: 8] = d[8*b +: 8];
  endfunction

  function automatic void push_cell(int row, int col, logic [7:0] ch, logic [7:0] at);
    push_write((col % 2) != 0 ? 4'b1100 : 4'b0011, 7'(row * 8 + col / 2), {at, ch, at, ch});
  endfunction

  function automatic void push_clear();
    for (int i = 0; i < 64; i++) push_write(4'hF, 7'(i), 32'd0);
  endfunction

  function automatic void push_scroll();
    for (int w = 0; w < 56; w++) push_write(4'hF, 7'(w), shadow[w + 8]);
    for (int w = 56; w < 64; w++) push_write(4'hF, 7'(w), 32'd0);
  endfunction

  // Called at a negedge; returns at the negedge just after acceptance.
  task automatic send(input logic [7:0] c, input logic [7:0] a, output int waited);
    in_valid = 1'b1; in_char = c; in_attr = a; waited = 0;
    while (!in_ready && waited < 400) begin
      @(negedge clk); waited++;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Number of not-ready cycles starting from the next negedge.
  task automatic wait_ready(output int cyc);
    cyc = 0;
    @(negedge clk);
    while (!in_ready && cyc < 400) begin
      cyc++; @(negedge clk);
    end
  endtask

  task automatic test_reset();
    int cyc;
    rst = 1'b1;
    @(negedge clk);
    total_cnt++;
    if ({ram_we, ram_addr, ram_data} !== 43'd0)
      $display("FAIL rst_port: got we=%h addr=%0d data=%h, required all 0", ram_we, ram_addr, ram_data);
    else pass_cnt++;
    total_cnt++;
    if ({in_ready, busy, cursor_row, cursor_col} !== {1'b0, 1'b1, 3'd0, 4'd0})
      $display("FAIL rst_state: got rdy=%b busy=%b cur=(%0d,%0d), required 0 1 (0,0)",
               in_ready, busy, cursor_row, cursor_col);
    else pass_cnt++;
    push_clear();
    rst = 1'b0;
    wait_ready(cyc);
    total_cnt++;
    if (cyc !== 64) $display("FAIL rst_clear_len: got %0d busy cycles, required 64", cyc);
    else pass_cnt++;
    total_cnt++;
    if ({cursor_row, cursor_col, busy} !== {3'd0, 4'd0, 1'b0})
      $display("FAIL rst_cursor: got (%0d,%0d) busy=%b, required (0,0) 0", cursor_row, cursor_col, busy);
    else pass_cnt++;
  endtask

  task automatic test_put();
    int w;
    push_cell(0, 0, 8'h41, 8'h0F);
    send(8'h41, 8'h0F, w);
    total_cnt++;
    if ({ram_we, ram_addr, ram_data, in_ready} !== {4'b0011, 7'd0, 32'h0F410F41, 1'b0})
      $display("FAIL put_a: got we=%h addr=%0d data=%h rdy=%b, required 3 0 0f410f41 0",
               ram_we, ram_addr, ram_data, in_ready);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({in_ready, cursor_row, cursor_col} !== {1'b1, 3'd0, 4'd1})
      $display("FAIL put_a_after: got rdy=%b cur=(%0d,%0d), required 1 (0,1)", in_ready, cursor_row, cursor_col);
    else pass_cnt++;
    push_cell(0, 1, 8'h42, 8'h0F);
    send(8'h42, 8'h0F, w);
    total_cnt++;
    if ({ram_we, ram_addr, ram_data} !== {4'b1100, 7'd0, 32'h0F420F42})
      $display("FAIL put_b: got we=%h addr=%0d data=%h, required c 0 0f420f42", ram_we, ram_addr, ram_data);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({in_ready, cursor_col} !== {1'b1, 4'd2})
      $display("FAIL put_b_after: got rdy=%b col=%0d, required 1 2", in_ready, cursor_col);
    else pass_cnt++;
  endtask

  task automatic test_wrap_ctrl();
    int w;
    send(8'h0D, 8'h00, w);
    for (int i = 0; i < 16; i++) begin
      push_cell(0, i, 8'h61 + 8'(i), 8'h07);
      send(8'h61 + 8'(i), 8'h07, w);
    end
    @(negedge clk);
    total_cnt++;
    if ({cursor_row, cursor_col} !== {3'd1, 4'd0})
      $display("FAIL wrap_cursor: got (%0d,%0d), required (1,0)", cursor_row, cursor_col);
    else pass_cnt++;
    push_cell(1, 0, 8'h43, 8'h07);
    send(8'h43, 8'h07, w);
    total_cnt++;
    if ({ram_we, ram_addr} !== {4'b0011, 7'd8})
      $display("FAIL wrap_c: got we=%h addr=%0d, required 3 8", ram_we, ram_addr);
    else pass_cnt++;
    for (int i = 1; i < 5; i++) begin
      push_cell(1, i, 8'h44, 8'h07);
      send(8'h44, 8'h07, w);
    end
    @(negedge clk);
    total_cnt++;
    if ({cursor_row, cursor_col} !== {3'd1, 4'd5})
      $display("FAIL pre_cr: got (%0d,%0d), required (1,5)", cursor_row, cursor_col);
    else pass_cnt++;
    send(8'h0D, 8'h00, w);
    total_cnt++;
    if ({cursor_row, cursor_col, ram_we, in_ready} !== {3'd1, 4'd0, 4'h0, 1'b1})
      $display("FAIL cr: got (%0d,%0d) we=%h rdy=%b, required (1,0) 0 1", cursor_row, cursor_col, ram_we, in_ready);
    else pass_cnt++;
    send(8'h08, 8'h00, w);
    total_cnt++;
    if ({cursor_row, cursor_col, ram_we} !== {3'd0, 4'd15, 4'h0})
      $display("FAIL bs_wrap: got (%0d,%0d) we=%h, required (0,15) 0", cursor_row, cursor_col, ram_we);
    else pass_cnt++;
    send(8'h0D, 8'h00, w);
    send(8'h08, 8'h00, w);
    total_cnt++;
    if ({cursor_row, cursor_col, ram_we} !== {3'd0, 4'd0, 4'h0})
      $display("FAIL bs_origin: got (%0d,%0d) we=%h, required (0,0) 0", cursor_row, cursor_col, ram_we);
    else pass_cnt++;
    send(8'h7F, 8'h00, w);
    send(8'h01, 8'h00, w);
    total_cnt++;
    if ({cursor_row, cursor_col, in_ready} !== {3'd0, 4'd0, 1'b1})
      $display("FAIL ignored: got (%0d,%0d) rdy=%b, required (0,0) 1", cursor_row, cursor_col, in_ready);
    else pass_cnt++;
  endtask

  task automatic test_scroll();
    int w, cyc;
    for (int k = 0; k < 64; k++) begin
      mem[k] <= 32'h1000 + 32'(k);
      shadow[k] = 32'h1000 + 32'(k);
    end
    for (int i = 0; i < 7; i++) send(8'h0A, 8'h00, w);
    total_cnt++;
    if ({cursor_row, cursor_col} !== {3'd7, 4'd0})
      $display("FAIL lf_rows: got (%0d,%0d), required (7,0)", cursor_row, cursor_col);
    else pass_cnt++;
    push_scroll();
    send(8'h0A, 8'h00, w);
    total_cnt++;
    if ({ram_we, ram_addr, in_ready} !== {4'h0, 7'd8, 1'b0})
      $display("FAIL sc_first_rd: got we=%h addr=%0d rdy=%b, required 0 8 0", ram_we, ram_addr, in_ready);
    else pass_cnt++;
    wait_ready(cyc);
    // 175 further busy cycles after the one sampled above: 176 in all.
    total_cnt++;
    if (cyc !== 175) $display("FAIL sc_len: got %0d more busy cycles, required 175", cyc);
    else pass_cnt++;
    total_cnt++;
    if ({cursor_row, cursor_col, exp_q.size()} !== {3'd7, 4'd0, 32'd0})
      $display("FAIL sc_done: got (%0d,%0d) pending=%0d, required (7,0) 0", cursor_row, cursor_col, exp_q.size());
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int w;
    for (int i = 0; i < 15; i++) begin
      push_cell(7, i, 8'h30 + 8'(i), 8'h2A);
      send(8'h30 + 8'(i), 8'h2A, w);
    end
    push_cell(7, 15, 8'h58, 8'h2A);
    push_scroll();
    push_cell(7, 0, 8'h59, 8'h3C);
    send(8'h58, 8'h2A, w);
    total_cnt++;
    if ({ram_we, ram_addr} !== {4'b1100, 7'd63})
      $display("FAIL held_x: got we=%h addr=%0d, required c 63", ram_we, ram_addr);
    else pass_cnt++;
    send(8'h59, 8'h3C, w);
    total_cnt++;
    if (w !== 177) $display("FAIL held_wait: got %0d wait cycles, required 177", w);
    else pass_cnt++;
    total_cnt++;
    if ({ram_we, ram_addr} !== {4'b0011, 7'd56})
      $display("FAIL held_y: got we=%h addr=%0d, required 3 56", ram_we, ram_addr);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({cursor_row, cursor_col, exp_q.size()} !== {3'd7, 4'd1, 32'd0})
      $display("FAIL held_done: got (%0d,%0d) pending=%0d, required (7,1) 0", cursor_row, cursor_col, exp_q.size());
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int w, cyc;
    send(8'h0A, 8'h00, w);
    @(negedge clk);
    total_cnt++;
    if ({ram_we, ram_addr} !== {4'h0, 7'd8})
      $display("FAIL mid_wait: got we=%h addr=%0d, required 0 8", ram_we, ram_addr);
    else pass_cnt++;
    rst = 1'b1;
    @(negedge clk);
    total_cnt++;
    if ({ram_we, in_ready, cursor_row, cursor_col} !== {4'h0, 1'b0, 3'd0, 4'd0})
      $display("FAIL mid_rst: got we=%h rdy=%b cur=(%0d,%0d), required 0 0 (0,0)",
               ram_we, in_ready, cursor_row, cursor_col);
    else pass_cnt++;
    push_clear();
    rst = 1'b0;
    wait_ready(cyc);
    total_cnt++;
    if (cyc !== 64) $display("FAIL mid_clear_len: got %0d, required 64", cyc);
    else pass_cnt++;
    push_cell(0, 0, 8'h5A, 8'h1E);
    send(8'h5A, 8'h1E, w);
    @(negedge clk);
    push_clear();
    send(8'h0C, 8'h00, w);
    total_cnt++;
    if ({ram_we, ram_addr, in_ready} !== {4'hF, 7'd0, 1'b0})
      $display("FAIL ff_first: got we=%h addr=%0d rdy=%b, required f 0 0", ram_we, ram_addr, in_ready);
    else pass_cnt++;
    wait_ready(cyc);
    total_cnt++;
    if (cyc !== 63) $display("FAIL ff_len: got %0d more busy cycles, required 63", cyc);
    else pass_cnt++;
    total_cnt++;
    if ({cursor_row, cursor_col, exp_q.size()} !== {3'd0, 4'd0, 32'd0})
      $display("FAIL ff_done: got (%0d,%0d) pending=%0d, required (0,0) 0", cursor_row, cursor_col, exp_q.size());
    else pass_cnt++;
  endtask

  initial begin
    for (int k = 0; k < 64; k++) begin
      mem[k] <= 32'd0;
      shadow[k] = 32'd0;
    end
    test_reset();
    test_put();
    test_wrap_ctrl();
    test_scroll();
    test_back_to_back();
    test_reset_mid();
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/char_console.md
Name: char_console

Overview:
Text-console writer that fills the character RAM the tile renderer reads. It accepts a stream of 8-bit character codes with 8-bit attributes and writes 16-bit cells {attr, char} through the RAM's 32-bit byte-enabled CPU-side port. It maintains a cursor and interprets control codes. When the cursor passes the bottom row, the block scrolls by reading the RAM back and rewriting it.

Parameters:
COLS, 16, cells per row; must be even.
ROWS, 8, rows on screen; COLS*ROWS/2 must not exceed 128 words.

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
in_valid  input  1  character available
in_ready  output  1  block can accept a character this cycle
in_char  input  8  character code
in_attr  input  8  attribute byte, stored in cell bits [15:8]
ram_we  output  4  byte write enables for the RAM port; 0 means read
ram_addr  output  7  RAM word address
ram_data  output  32  RAM write data
ram_q  input  32  RAM read data; valid the cycle after the address is presented with ram_we=0
cursor_col  output  $clog2(COLS)  current column
cursor_row  output  $clog2(ROWS)  current row
busy  output  1  high in any state other than IDLE; equals !in_ready

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- All outputs are registered.
- Reset values: ram_we=0, ram_addr=0, ram_data=0, cursor=(0,0), in_ready=0, state=CLEAR.
- Reset in any state, including mid-scroll or mid-write, aborts the operation. ram_we is 0 in the cycle after rst is sampled high. After rst falls, the full clear sequence runs.
- Cell mapping:
  - word = row*COLS/2 + col/2.
  - Even col: ram_we=4'b0011. Odd col: ram_we=4'b1100.
  - ram_data = {attr,char,attr,char} for every write.
- Handshake:
  - A character is accepted when in_valid && in_ready.
  - in_ready is high only in IDLE.
  - The source holds in_char/in_attr stable until accepted.
- States:
  - IDLE
  - PUT
  - CLEAR
  - SC_RD
  - SC_WAIT
  - SC_WR
  - CLR_ROW
- Printable character (0x20–0x7E, 0x80–0xFF):
  - The cycle after acceptance is PUT: one write with the mapping above.
  - Cursor advances at the end of PUT. col==COLS-1 wraps to col 0 and row+1.
  - If row would reach ROWS, go to SC_RD with row held at ROWS-1. Otherwise return to IDLE, so in_ready is high 2 cycles after acceptance.
- Control codes: consumed with no RAM write, state stays IDLE, cursor updates the next cycle.
  - 0x0D (CR): col=0.
  - 0x0A (LF): col=0, row+1. At row ROWS-1, col=0 and go to SC_RD.
  - 0x08 (BS): col>0 gives col-1. col==0 && row>0 gives (row-1, COLS-1). At (0,0), no change. The cell is not erased.
  - 0x0C (FF): go to CLEAR, cursor=(0,0).
  - Other codes <0x20 and 0x7F: ignored.
- CLEAR:
  - Writes addr 0..COLS*ROWS/2-1, one per cycle, ram_we=4'b1111, ram_data=0.
  - Then IDLE.
- Scroll, for each destination word w = 0..(ROWS-1)*COLS/2-1:
  - SC_RD: ram_addr=w+COLS/2, ram_we=0.
  - SC_WAIT: address held, ram_we=0; ram_q is captured.
  - SC_WR: ram_addr=w, ram_we=4'b1111, ram_data=captured word.
  - Each word takes exactly 3 cycles.
- CLR_ROW:
  - Writes zero to words (ROWS-1)*COLS/2..COLS*ROWS/2-1, one per cycle.
  - Then IDLE, cursor=(ROWS-1,0).
- Default timing: scroll is busy for 56*3+8 = 176 cycles. CLEAR is busy for 64 cycles.
- Outside write cycles ram_we=0. ram_addr/ram_data may hold their last value.

Test Plan:
1. Pulse rst for 1 cycle, then release.
   -> 64 consecutive writes to addr 0..63 with we=4'hF, data=0.
   -> in_ready low during those 64 cycles, then high; cursor=(0,0).
2. From (0,0), send 'A' (0x41) with attr 0x0F, then 'B' (0x42) with attr 0x0F.
   -> 'A': 1 cycle after acceptance, we=4'b0011, addr=0, data=0x0F410F41; cursor col=1.
   -> 'B': we=4'b1100, addr=0, data=0x0F420F42.
   -> in_ready returns 2 cycles after each acceptance.
3. Send 16 printable characters, then 'C'.
   -> cursor=(1,0) after the 16th.
   -> 'C' written to addr 8 with we=4'b0011.
   -> CR at (1,5) gives (1,0). BS at (1,0) gives (0,15). BS at (0,0) leaves (0,0). None of these writes RAM.
4. Preload word k = 32'h1000+k, set cursor to row 7, send LF.
   -> 56 triples: read addr w+8, then write addr w with data 32'h1000+w+8.
   -> Then zero writes to addr 56..63.
   -> in_ready low for 176 cycles; final cursor=(7,0).
5. Print at (7,15), hold in_valid high with the next character during the scroll.
   -> Cell written at addr 63, we=4'b1100, then scroll runs.
   -> The held character is accepted only after scroll completes and is written at addr 56, we=4'b0011.
6. Assert rst during SC_WAIT of the scroll.
   -> ram_we=0 the next cycle.
   -> After release, the full 64-word clear runs; cursor=(0,0).
   -> FF (0x0C) sent later also produces the 64-word clear.
